// File: rtl/fifo_se_pkg.sv
// Shared types for the fifo_se queue element and its on-chip test fixture.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package fifo_se_pkg;

  // Requested operation for one clock edge, before full/empty qualification.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Fixture sequencer states.
  typedef enum logic [2:0] {
    FX_IDLE  = 3'd0,
    FX_FILL  = 3'd1,
    FX_CHKF  = 3'd2,
    FX_DRAIN = 3'd3,
    FX_CHKE  = 3'd4,
    FX_DONE  = 3'd5
  } fixture_state_e;

  function automatic fifo_op_e decode_op(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/fifo_se_mem.sv
// Storage array for fifo_se: DEPTH x DATA_WIDTH, one sync write, one async read.
// Latency: write visible on rdata the cycle after the write edge; read is combinational.
// Backpressure: none; the caller qualifies we.
// Ports: i_clk; i_we/i_waddr/i_wdata write port; i_raddr/o_rdata read port. No reset.
module fifo_se_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/fifo_se_test.sv
// Self-checking on-chip fixture: fills an 8x16 fifo_se with 1..8, then drains and checks order.
// Latency: about 20 cycles from i_run rising to o_running falling.
// Backpressure: none; i_run low holds the fixture and its FIFO in reset.
// Ports: i_clk; i_run start/hold; o_running busy; o_passed result, valid once o_running falls.
module fifo_se_test
  import fifo_se_pkg::*;
(
  input  logic i_clk,
  input  logic i_run,
  output logic o_running,
  output logic o_passed
);

  fixture_state_e state_q;
  logic [2:0]     idx_q;
  logic           ok_q;
  logic           running_q;
  logic           passed_q;

  logic [15:0] fifo_rdata;
  logic        fifo_empty;
  logic        fifo_full;
  logic [3:0]  fifo_count;
  logic        fifo_err;
  logic        fifo_push;
  logic        fifo_pop;
  logic [15:0] fifo_wdata;
  logic [15:0] expect_dat;

  assign fifo_push  = (state_q == FX_FILL);
  assign fifo_pop   = (state_q == FX_DRAIN);
  assign expect_dat = 16'(idx_q) + 16'd1;
  assign fifo_wdata = expect_dat;

  // No dedicated reset pin on the fixture: i_run low is the reset.
  always_ff @(posedge i_clk) begin
    if (!i_run) begin
      state_q   <= FX_IDLE;
      idx_q     <= '0;
      ok_q      <= 1'b0;
      running_q <= 1'b0;
      passed_q  <= 1'b0;
    end else begin
      case (state_q)
        FX_IDLE: begin
          state_q   <= FX_FILL;
          idx_q     <= '0;
          ok_q      <= 1'b1;
          running_q <= 1'b1;
          passed_q  <= 1'b0;
        end
        FX_FILL: begin
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'd7) state_q <= FX_CHKF;
        end
        FX_CHKF: begin
          if (!fifo_full || fifo_count != 4'd8 || fifo_rdata != 16'd1) ok_q <= 1'b0;
          idx_q   <= '0;
          state_q <= FX_DRAIN;
        end
        FX_DRAIN: begin
          if (fifo_empty || fifo_rdata != expect_dat) ok_q <= 1'b0;
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'd7) state_q <= FX_CHKE;
        end
        FX_CHKE: begin
          state_q   <= FX_DONE;
          running_q <= 1'b0;
          passed_q  <= ok_q && fifo_empty && !fifo_err && (fifo_count == 4'd0);
        end
        FX_DONE: begin
        end
        default: state_q <= FX_IDLE;
      endcase
    end
  end

  fifo_se #(
    .DATA_WIDTH (16),
    .DEPTH      (8)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_run),
    .i_data  (fifo_wdata),
    .i_push  (fifo_push),
    .i_pop   (fifo_pop),
    .o_data  (fifo_rdata),
    .o_empty (fifo_empty),
    .o_full  (fifo_full),
    .o_count (fifo_count),
    .o_err   (fifo_err)
  );

  assign o_running = running_q;
  assign o_passed  = passed_q;

endmodule

// File: rtl/fifo_se.sv
// Single-clock first-word-fall-through FIFO with sticky overflow/underflow flag.
// Latency: pushed word visible on o_data one cycle after the push edge; no bypass.
// Backpressure: push while full / pop while empty is dropped and sets o_err.
// Ports: i_clk, i_rst_n (async, active-low); i_data/i_push enqueue; i_pop dequeue;
//        o_data head word; o_empty, o_full, o_count occupancy; o_err sticky error.
module fifo_se
  import fifo_se_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [DATA_WIDTH-1:0]     i_data,
  input  logic                      i_push,
  input  logic                      i_pop,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic                      o_empty,
  output logic                      o_full,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_err
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  err_q, err_d;

  logic     empty;
  logic     full;
  logic     do_wr;
  logic     do_rd;
  fifo_op_e op;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_WIDTH'(DEPTH));
  assign op    = decode_op(i_push, i_pop);

  always_comb begin
    do_wr = 1'b0;
    do_rd = 1'b0;
    err_d = err_q;
    case (op)
      OP_PUSH: begin
        if (full) err_d = 1'b1;
        else      do_wr = 1'b1;
      end
      OP_POP: begin
        if (empty) err_d = 1'b1;
        else       do_rd = 1'b1;
      end
      OP_BOTH: begin
        // On empty only the push can happen; the pop is the error.
        // When full, head==tail: the async read already presents the old head,
        // so overwriting that slot on the same edge is safe.
        do_wr = 1'b1;
        if (empty) err_d = 1'b1;
        else       do_rd = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_rd) head_d = head_q + 1'b1;
    if (do_wr) tail_d = tail_q + 1'b1;
    if (do_wr && !do_rd)      count_d = count_q + 1'b1;
    else if (do_rd && !do_wr) count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  fifo_se_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (do_wr),
    .i_waddr (tail_q),
    .i_wdata (i_data),
    .i_raddr (head_q),
    .o_rdata (o_data)
  );

  assign o_empty = empty;
  assign o_full  = full;
  assign o_count = count_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_fifo_se.sv
// Directed bench for fifo_se (8 x 16) plus a run of the on-chip fixture.
// Latency: n/a.
// Backpressure: n/a.
module tb_fifo_se;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din;
  logic        push;
  logic        pop;
  logic [15:0] dout;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        err;

  logic run;
  logic running;
  logic passed;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_se #(
    .DATA_WIDTH (16),
    .DEPTH      (8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (din),
    .i_push  (push),
    .i_pop   (pop),
    .o_data  (dout),
    .o_empty (empty),
    .o_full  (full),
    .o_count (count),
    .o_err   (err)
  );

  fifo_se_test fixture (
    .i_clk     (clk),
    .i_run     (run),
    .o_running (running),
    .o_passed  (passed)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive one edge's worth of inputs; returns at posedge+1.
  task automatic cyc(input logic p, input logic q, input logic [15:0] d);
    push = p;
    pop  = q;
    din  = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    din  = 16'h0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [15:0] model[$];
  logic [15:0] exp_v;
  bit          seen_run;
  bit          fix_done;

  initial begin
    rst_n = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    din   = 16'h0000;
    run   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    rst_n = 1'b1;

    // Reset then idle
    cyc(0, 0, 16'h0000);
    cyc(0, 0, 16'h0000);
    chk("idle_empty", empty, 1);
    chk("idle_full",  full,  0);
    chk("idle_count", count, 0);
    chk("idle_err",   err,   0);

    // First push appears one cycle after its edge
    cyc(1, 0, 16'h0001);
    chk("first_push_data",  dout,  16'h0001);
    chk("first_push_count", count, 1);
    chk("first_push_empty", empty, 0);
    for (int i = 2; i <= 8; i++) cyc(1, 0, 16'(i));
    chk("fill_count", count, 8);
    chk("fill_full",  full,  1);
    chk("fill_head",  dout,  16'h0001);

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      chk("drain_data", dout, 32'(i));
      cyc(0, 1, 16'h0000);
    end
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    chk("drain_err",   err,   0);

    // Refill, then overflow
    for (int i = 1; i <= 8; i++) cyc(1, 0, 16'(i));
    cyc(1, 0, 16'hDEAD);
    chk("ovf_count", count, 8);
    chk("ovf_head",  dout,  16'h0001);
    chk("ovf_err",   err,   1);

    // Push+pop while full
    cyc(1, 1, 16'h0009);
    chk("fullpp_count", count, 8);
    chk("fullpp_data",  dout,  16'h0002);
    chk("fullpp_err",   err,   1);
    for (int i = 2; i <= 9; i++) begin
      chk("fullpp_drain", dout, 32'(i));
      cyc(0, 1, 16'h0000);
    end
    chk("fullpp_empty", empty, 1);

    // Underflow after reset
    do_reset();
    chk("post_rst_err", err, 0);
    cyc(0, 1, 16'h0000);
    chk("udf_count", count, 0);
    chk("udf_empty", empty, 1);
    chk("udf_err",   err,   1);

    // Push+pop with {5,6}
    do_reset();
    cyc(1, 0, 16'h0005);
    cyc(1, 0, 16'h0006);
    cyc(1, 1, 16'h0007);
    chk("pp_count", count, 2);
    chk("pp_data",  dout,  16'h0006);
    cyc(0, 1, 16'h0000);
    chk("pp_next",  dout,  16'h0007);
    chk("pp_count1", count, 1);
    cyc(0, 1, 16'h0000);
    chk("pp_empty", empty, 1);
    chk("pp_err",   err,   0);

    // Push+pop on empty, then alternating traffic across pointer wrap
    do_reset();
    cyc(1, 1, 16'h00AA);
    chk("epp_count", count, 1);
    chk("epp_data",  dout,  16'h00AA);
    chk("epp_err",   err,   1);
    model.delete();
    model.push_back(16'h00AA);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 16'h0100 + 16'(i));
      model.push_back(16'h0100 + 16'(i));
      chk("alt_count", count, 2);
      exp_v = model.pop_front();
      chk("alt_data", dout, exp_v);
      cyc(0, 1, 16'h0000);
    end
    chk("alt_left_count", count, 1);
    chk("alt_left_data",  dout,  16'h0113);

    // Asynchronous reset between edges
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1, 0, 16'h0020 + 16'(i));
    chk("mid_count", count, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_empty", empty, 1);
    #2;
    rst_n = 1'b1;
    cyc(1, 0, 16'h1234);
    chk("after_rst_data",  dout,  16'h1234);
    chk("after_rst_count", count, 1);
    chk("after_rst_err",   err,   0);

    // On-chip fixture
    run      = 1'b1;
    seen_run = 0;
    fix_done = 0;
    for (int n = 0; n < 200 && !fix_done; n++) begin
      @(posedge clk);
      #1;
      if (running) seen_run = 1;
      else if (seen_run) fix_done = 1;
    end
    chk("fixture_done",   fix_done, 1);
    chk("fixture_passed", passed,   1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
